// File: rtl/mdu_pkg.sv
// Shared decode constants and state encoding for the multiply/divide unit.
// The funct codes are the single source for both the ALU and the MDU decoders.
package mdu_pkg;

    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_iter_op(input logic [5:0] op);
        return (op == FUNCT_MULT) || (op == FUNCT_MULTU) ||
               (op == FUNCT_DIV)  || (op == FUNCT_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == FUNCT_MULT) || (op == FUNCT_MULTU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] op);
        return (op == FUNCT_MULT) || (op == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring divider datapath: one quotient bit per step on unsigned
// operands. Exposes the next-step quotient/remainder so the final step can be
// committed straight into Hi/Lo.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_nxt,
    output logic [WIDTH-1:0] rem_nxt
);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   minuend;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // The true difference is always below 2^WIDTH when it fits, so the low
    // WIDTH bits of the subtraction are exact.
    always_comb begin
        minuend = {rem_q, quo_q[WIDTH-1]};
        fits    = (minuend >= {1'b0, dsr_q});
        diff    = minuend[WIDTH-1:0] - dsr_q;
        rem_nxt = fits ? diff : minuend[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], fits};

        quo_d = quo_q;
        rem_d = rem_q;
        dsr_d = dsr_q;
        if (load) begin
            quo_d = dividend;
            rem_d = '0;
            dsr_d = divisor;
        end else if (step) begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
        end
    end

endmodule

// File: rtl/mdu.sv
// MIPS multiply/divide unit: owns Hi/Lo, runs mult/div over WIDTH cycles and
// applies the signed fix-up on the final cycle.
//   state   | meaning
//   IDLE    | Hi/Lo stable, Start with a legal Op is accepted
//   RUN     | mult/div iterating, one bit per cycle, Start ignored
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [5:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_nxt, rem_nxt;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               div_load, div_step;

    assign op_signed = is_signed_op(Op);
    assign mag_a     = (op_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b     = (op_signed && B[WIDTH-1]) ? -B : B;

    // Shift-add: upper half accumulates, multiplier bits retire from the bottom.
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                       (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    assign prod_fix  = neg_res_q ? -prod_step : prod_step;
    assign quo_fix   = neg_res_q ? -quo_nxt : quo_nxt;
    assign rem_fix   = neg_rem_q ? -rem_nxt : rem_nxt;

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk     (clk),
        .reset   (reset),
        .load    (div_load),
        .step    (div_step),
        .dividend(mag_a),
        .divisor (mag_b),
        .quo_nxt (quo_nxt),
        .rem_nxt (rem_nxt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_load   = 1'b0;
        div_step   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Op == FUNCT_MTHI) begin
                        hi_d = A;
                    end else if (Op == FUNCT_MTLO) begin
                        lo_d = A;
                    end else if (is_iter_op(Op)) begin
                        state_d    = ST_RUN;
                        cnt_d      = '0;
                        op_d       = Op;
                        a_d        = A;
                        neg_res_d  = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem_d  = op_signed && A[WIDTH-1];
                        div_zero_d = (B == '0);
                        mcand_d    = mag_a;
                        prod_d     = {{WIDTH{1'b0}}, mag_b};
                        div_load   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_mul_op(op_q)) begin
                    prod_d = prod_step;
                end else begin
                    div_step = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (is_mul_op(op_q)) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (div_zero_q) begin
                        // Divide by zero leaves the dividend visible in Hi.
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            mcand_q    <= '0;
            prod_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign Busy = (state_q == ST_RUN);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
